// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute stage: ALU opcodes, sequencer
// state encoding and default geometry.
package vec_pkg;

    localparam int WIDTH_DEF = 19;
    localparam int LANES_DEF = 4;
    localparam int SELW_DEF  = 4;

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: latches a vector operand bundle, walks the shared
// scalar ALU across the lanes one element per cycle, collects results and
// flags per lane, and hands the result bundle to writeback via valid/ready.
module vec_alu_sequencer
    import vec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF,
    parameter int SELW  = SELW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [SELW-1:0]        in_sel,
    input  logic                   in_bcast,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [SELW-1:0]        alu_sel,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_n,
    input  logic                   alu_z,
    input  logic                   alu_v,
    input  logic                   alu_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_res,
    output logic [LANES-1:0]       out_n,
    output logic [LANES-1:0]       out_z,
    output logic [LANES-1:0]       out_v,
    output logic [LANES-1:0]       out_c,
    output logic                   out_any_v,
    output logic                   out_all_z
);

    localparam int CW = $clog2(LANES);

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic [CW-1:0]          r_cnt;
    logic [LANES*WIDTH-1:0] r_a;
    logic [LANES*WIDTH-1:0] r_b;
    logic [SELW-1:0]        r_sel;
    logic                   r_bcast;
    logic [LANES*WIDTH-1:0] r_res;
    logic [LANES-1:0]       r_n;
    logic [LANES-1:0]       r_z;
    logic [LANES-1:0]       r_v;
    logic [LANES-1:0]       r_c;
    logic                   w_accept;
    logic                   w_last;
    int                     w_lane;

    // Handshake and lane bookkeeping. Gating in_ready with rst keeps an
    // accept from appearing on the same edge that reset wins.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CW'(LANES - 1));
    assign w_lane    = int'(r_cnt);

    // State register: reset aborts whatever bundle is in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic: RUN lasts exactly LANES cycles, DONE waits for writeback.
    always_comb begin
        // NOTE: default first so no path through the case leaves the
        // signal unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand latches, loaded only on accept.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are only read in RUN, which can only be
        // entered through an accept that loads them.
        if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_sel   <= in_sel;
            r_bcast <= in_bcast;
        end
    end

    // Lane counter and per-lane result/flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_res <= '0;
            r_n   <= '0;
            r_z   <= '0;
            r_v   <= '0;
            r_c   <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_res <= '0;
            r_n   <= '0;
            r_z   <= '0;
            r_v   <= '0;
            r_c   <= '0;
        end else if (r_state == RUN) begin
            r_res[w_lane*WIDTH +: WIDTH] <= alu_out;
            r_n[r_cnt]                   <= alu_n;
            r_z[r_cnt]                   <= alu_z;
            r_v[r_cnt]                   <= alu_v;
            r_c[r_cnt]                   <= alu_c;
            r_cnt                        <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    // ALU operand steering: lane k of A, lane k (or lane 0 when broadcasting) of B.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        if (r_state == RUN) begin
            alu_a   = r_a[w_lane*WIDTH +: WIDTH];
            alu_b   = r_bcast ? r_b[WIDTH-1:0] : r_b[w_lane*WIDTH +: WIDTH];
            alu_sel = r_sel;
        end
    end

    // Result presentation; aggregates are only meaningful while the bundle is valid.
    assign out_valid = (r_state == DONE);
    assign out_res   = r_res;
    assign out_n     = r_n;
    assign out_z     = r_z;
    assign out_v     = r_v;
    assign out_c     = r_c;
    assign out_any_v = out_valid && (|r_v);
    assign out_all_z = out_valid && (&r_z);

endmodule
